// File: rtl/truth_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_sweep_checker_if
// Description : Stimulus/response and result bundle between a sweep
//               controller (master) and the truth_sweep_checker (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_sweep_checker_if;
  logic        start;
  logic [31:0] expected;
  logic        F_in;
  logic        X;
  logic        Y;
  logic        Z;
  logic        K;
  logic        M;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_count;
  logic        err_valid;
  logic [4:0]  first_err_idx;
  logic [31:0] captured;

  modport master (
    output start, expected, F_in,
    input  X, Y, Z, K, M, busy, done, pass, err_count, err_valid,
           first_err_idx, captured
  );

  modport slave (
    input  start, expected, F_in,
    output X, Y, Z, K, M, busy, done, pass, err_count, err_valid,
           first_err_idx, captured
  );
endinterface
`default_nettype wire

// File: rtl/truth_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : truth_sweep_checker
// Description : Walks all 32 input vectors of a 5-input combinational
//               function, samples its response after SETTLE cycles and
//               compares it against a latched golden truth table.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_sweep_checker #(
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last value of the settle counter before the vector is sampled.
  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        w_busy;
  logic        w_done;
  logic        w_mismatch;

  logic [4:0]  r_index;
  logic [3:0]  r_settle_cnt;
  logic [4:0]  r_vec;
  logic [31:0] r_expected;
  logic [31:0] r_captured;
  logic [5:0]  r_err_count;
  logic        r_err_valid;
  logic [4:0]  r_first_err_idx;
  logic        r_pass;

  assign w_mismatch = (bus.F_in != r_expected[r_index]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_busy = 1'b1;
        if (r_settle_cnt == c_SETTLE_LAST) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_busy       = 1'b1;
        w_state_next = (r_index == 5'd31) ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sweep datapath: vector stepping, response capture and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index         <= 5'd0;
      r_settle_cnt    <= 4'd0;
      r_vec           <= 5'd0;
      r_expected      <= 32'd0;
      r_captured      <= 32'd0;
      r_err_count     <= 6'd0;
      r_err_valid     <= 1'b0;
      r_first_err_idx <= 5'd0;
      r_pass          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // Golden table is frozen here so later input changes cannot disturb the sweep.
            r_expected      <= bus.expected;
            r_index         <= 5'd0;
            r_settle_cnt    <= 4'd0;
            r_vec           <= 5'd0;
            r_captured      <= 32'd0;
            r_err_count     <= 6'd0;
            r_err_valid     <= 1'b0;
            r_first_err_idx <= 5'd0;
            r_pass          <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_settle_cnt != c_SETTLE_LAST) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_captured[r_index] <= bus.F_in;
          r_settle_cnt        <= 4'd0;
          if (w_mismatch) begin
            if (r_err_count != 6'd32) begin
              r_err_count <= r_err_count + 6'd1;
            end
            if (!r_err_valid) begin
              r_first_err_idx <= r_index;
              r_err_valid     <= 1'b1;
            end
          end
          if (r_index == 5'd31) begin
            // Verdict includes the final vector so it is valid during the done pulse.
            r_vec  <= 5'd0;
            r_pass <= !w_mismatch && (r_err_count == 6'd0);
          end else begin
            r_index <= r_index + 5'd1;
            r_vec   <= r_index + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.X             = r_vec[4];
  assign bus.Y             = r_vec[3];
  assign bus.Z             = r_vec[2];
  assign bus.K             = r_vec[1];
  assign bus.M             = r_vec[0];
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err_count;
  assign bus.err_valid     = r_err_valid;
  assign bus.first_err_idx = r_first_err_idx;
  assign bus.captured      = r_captured;

endmodule
`default_nettype wire
